// File: rtl/midori_ti_share_sequencer_pkg.sv
// Shared types and constants for the Midori64 TI share sequencer.
package midori_ti_pkg;

    localparam int unsigned ShareW             = 64;
    localparam int unsigned NibbleW            = 4;
    localparam int unsigned RowW               = 16;
    localparam int unsigned NumRows            = ShareW / RowW;
    localparam int unsigned RoundW             = 4;
    localparam int unsigned DefaultNumRounds   = 16;
    localparam int unsigned DefaultRoundCycles = 2;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/midori_ti_share_sequencer_if.sv
// Input and result handshakes of the share sequencer.
// slave: sequencer side; master: share source / result consumer side.
interface midori_ti_share_sequencer_if;
    import midori_ti_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [ShareW-1:0] in_share0;
    logic [ShareW-1:0] in_share1;
    logic [ShareW-1:0] in_share2;
    logic              row_mode;
    logic              out_valid;
    logic              out_ready;
    logic [ShareW-1:0] out_share0;
    logic [ShareW-1:0] out_share1;
    logic [ShareW-1:0] out_share2;

    modport slave (
        input  in_valid, in_share0, in_share1, in_share2, row_mode, out_ready,
        output in_ready, out_valid, out_share0, out_share1, out_share2
    );

    modport master (
        output in_valid, in_share0, in_share1, in_share2, row_mode, out_ready,
        input  in_ready, out_valid, out_share0, out_share1, out_share2
    );

endinterface

// File: rtl/midori_ti_share_sequencer_remap.sv
// Combinational share remap. With NONUNIF_ROW_EN defined, row_mode selects a
// row-replicated remap that keeps the XOR of the three shares; otherwise the
// shares pass through and row_mode is ignored.
module midori_share_remap
    import midori_ti_pkg::*;
(
    input  logic [ShareW-1:0] share0_i,
    input  logic [ShareW-1:0] share1_i,
    input  logic [ShareW-1:0] share2_i,
    input  logic              row_mode_i,
    output logic [ShareW-1:0] share0_o,
    output logic [ShareW-1:0] share1_o,
    output logic [ShareW-1:0] share2_o
);

`ifdef NONUNIF_ROW_EN
    // Replicate the top row of shares 0/1; share 2 absorbs the difference.
    always_comb begin
        share0_o = share0_i;
        share1_o = share1_i;
        share2_o = share2_i;
        if (row_mode_i) begin
            share0_o = {NumRows{share0_i[ShareW-1 -: RowW]}};
            share1_o = {NumRows{share1_i[ShareW-1 -: RowW]}};
            share2_o = (share0_i ^ share1_i ^ share2_i) ^ share0_o ^ share1_o;
        end
    end
`else
    logic unused_row_mode;
    assign unused_row_mode = row_mode_i;

    assign share0_o = share0_i;
    assign share1_o = share1_i;
    assign share2_o = share2_i;
`endif

endmodule

// File: rtl/midori_ti_share_sequencer.sv
// Sequencer for the 3-share Midori64 TI core: accepts shares, loads the core,
// steps rounds, and returns the result shares. Optional row remap is enabled
// with the NONUNIF_ROW_EN macro.
module midori_ti_share_sequencer
    import midori_ti_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS   = DefaultNumRounds,
    parameter int unsigned ROUND_CYCLES = DefaultRoundCycles
) (
    input  logic                        clk,
    input  logic                        rst,
    midori_ti_share_sequencer_if.slave  bus,
    input  logic                        abort,
    output logic                        core_load,
    output logic [ShareW-1:0]           core_share0,
    output logic [ShareW-1:0]           core_share1,
    output logic [ShareW-1:0]           core_share2,
    output logic                        core_en,
    output logic [RoundW-1:0]           core_round,
    input  logic [ShareW-1:0]           core_res0,
    input  logic [ShareW-1:0]           core_res1,
    input  logic [ShareW-1:0]           core_res2,
    output logic                        busy
);

    localparam int unsigned CycW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
    localparam logic [CycW-1:0]   CycLast   = CycW'(ROUND_CYCLES - 1);
    localparam logic [RoundW-1:0] RoundLast = RoundW'(NUM_ROUNDS - 1);

    state_e            state_q, state_d;
    logic [CycW-1:0]   cyc_q, cyc_d;
    logic [RoundW-1:0] round_q, round_d;
    logic [ShareW-1:0] sh0_q, sh1_q, sh2_q;
    logic [ShareW-1:0] res0_q, res1_q, res2_q;
    logic [ShareW-1:0] map0, map1, map2;
    logic              accept;
    logic              capture;

    midori_share_remap u_remap (
        .share0_i   (bus.in_share0),
        .share1_i   (bus.in_share1),
        .share2_i   (bus.in_share2),
        .row_mode_i (bus.row_mode),
        .share0_o   (map0),
        .share1_o   (map1),
        .share2_o   (map2)
    );

    // Next state, counters and capture strobes.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        round_d = round_q;
        accept  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cyc_d   = '0;
                round_d = '0;
                state_d = abort ? StIdle : StRun;
            end
            StRun: begin
                if (abort) begin
                    cyc_d   = '0;
                    round_d = '0;
                    state_d = StIdle;
                end else if (cyc_q == CycLast) begin
                    cyc_d = '0;
                    if (round_q == RoundLast) begin
                        // Final wrap: take the result while the core still presents it.
                        round_d = '0;
                        capture = 1'b1;
                        state_d = StDone;
                    end else begin
                        round_d = round_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cyc_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            round_q <= round_d;
        end
    end

    // Core input shares, captured on the input handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh0_q <= '0;
            sh1_q <= '0;
            sh2_q <= '0;
        end else if (accept) begin
            sh0_q <= map0;
            sh1_q <= map1;
            sh2_q <= map2;
        end
    end

    // Result shares, captured at the last round wrap and held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res0_q <= '0;
            res1_q <= '0;
            res2_q <= '0;
        end else if (capture) begin
            res0_q <= core_res0;
            res1_q <= core_res1;
            res2_q <= core_res2;
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.out_valid  = (state_q == StDone);
    assign bus.out_share0 = res0_q;
    assign bus.out_share1 = res1_q;
    assign bus.out_share2 = res2_q;
    assign core_load      = (state_q == StLoad);
    assign core_en        = (state_q == StRun);
    assign core_round     = round_q;
    assign core_share0    = sh0_q;
    assign core_share1    = sh1_q;
    assign core_share2    = sh2_q;
    assign busy           = (state_q != StIdle);

endmodule

// File: doc/midori_ti_share_sequencer.md
# midori_ti_share_sequencer

Sequencer in front of the 3-share Midori64 threshold-implementation core. It accepts one set of input shares over a valid/ready handshake and, in row mode, re-maps them into row-replicated non-uniform randomness, preserving the unshared value. It then loads the core, steps the round counter and round-enable for the configured number of rounds, and returns the core's result shares over a second valid/ready handshake. It sits between the testbench or share source and the Midori TI datapath.

## Interface
- NUM_ROUNDS, 16: rounds per encryption; must be 1..16.
- ROUND_CYCLES, 2: clock cycles per round (TI register stages); must be ≥1.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input shares valid.
- in_ready  out  1  sequencer can accept shares.
- in_share0 / in_share1 / in_share2  in  64 each  input shares.
- row_mode  in  1  sampled with the input: 1 = row-replicated remap, 0 = passthrough.
- abort  in  1  synchronous abort of a running encryption.
- core_load  out  1  one-cycle pulse; core captures core_share0..2.
- core_share0 / core_share1 / core_share2  out  64 each  registered, remapped shares.
- core_en  out  1  core advances one register stage.
- core_round  out  4  current round index.
- core_res0 / core_res1 / core_res2  in  64 each  core output shares.
- out_valid  out  1  result shares valid.
- out_ready  in  1  consumer accepts the result.
- out_share0 / out_share1 / out_share2  out  64 each  captured result shares.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register the remapped shares and latch row_mode, then go to LOAD.
- LOAD: core_load=1 for exactly one cycle. Clear the round counter and cycle counter, then go to RUN.
- RUN: core_en=1 every cycle. cyc counts 0..ROUND_CYCLES-1.
  - At wrap, core_round increments.
  - At the wrap of round NUM_ROUNDS-1, capture core_res0..2 into out_share0..2 and go to DONE.
- DONE: out_valid=1, holding out_share values stable, until out_ready. On the handshake, go to IDLE.
- abort: honoured only in LOAD or RUN. The next state is IDLE, there is no out_valid, and out_share is unchanged. abort is ignored in IDLE and DONE.
- Remap, row mode (row i = bits 16i+15..16i, i=0..3):
  - Every row of core_share0 = in_share0[63:48].
  - Every row of core_share1 = in_share1[63:48].
  - core_share2 = (in_share0^in_share1^in_share2) ^ core_share0 ^ core_share1.
  - The XOR of all three shares is always preserved.
- Remap, passthrough: core_shareN = in_shareN.
- in_ready is asserted only in IDLE. No new input is accepted in the cycle that completes the DONE handshake.

## Timing
- Reset values: state IDLE, in_ready=1; all other outputs 0, including all core_share, out_share, core_round and busy.
- Let the input handshake occur at edge t:
  - LOAD occupies cycle t+1.
  - RUN occupies cycles t+2 .. t+1+NUM_ROUNDS·ROUND_CYCLES.
  - out_valid rises in cycle t+2+NUM_ROUNDS·ROUND_CYCLES (t+34 with defaults).
- core_round equals k during RUN cycles t+2+k·ROUND_CYCLES .. t+1+(k+1)·ROUND_CYCLES. It returns to 0 in DONE.
- out_valid with out_ready in the same cycle as it rises: the handshake completes and in_ready=1 in the next cycle.
- Reset mid-RUN: all outputs return immediately to their reset values. Any pending result is discarded.

## Configuration
- NONUNIF_ROW_EN defined: row_mode is honoured as above.
- NONUNIF_ROW_EN undefined: the remap logic is absent and row_mode is ignored. Shares always pass through unchanged.

## Structure
- Package midori_ti_pkg holds:
  - the state enum;
  - the share width constant (64), nibble and row widths;
  - the default NUM_ROUNDS.
- Sub-module midori_share_remap is combinational: three shares plus row_mode in, three shares out. Its body is wrapped in the NONUNIF_ROW_EN guard.
- The sequencer contains the FSM, the counters and the share/result registers.

## Test plan
- Reset, then release → in_ready=1, busy=0, out_valid=0, core_round=0, all share outputs 0.
- Row mode: s0=0x0123456789ABCDEF, s1=0xFEDCBA9876543210, s2=0 → core_share0=0x0123012301230123, core_share1=0xFEDCFEDCFEDCFEDC, core_share2=0x0000000000000000.
- Passthrough (row_mode=0) with the same shares → core_share0..2 equal the inputs; core_load is a single pulse at t+1.
- Defaults with a stub core returning constants → core_round steps 0..15 every 2 cycles; out_valid at t+34 with the stub values.
- Backpressure: out_ready=0 for 5 cycles → out_valid and out_share held stable, in_ready=0; out_ready=1 → IDLE next cycle.
- abort in round 7, and separately rst asserted in round 7 → IDLE, no out_valid; a following encryption completes with correct latency.
